// File: rtl/find_extreme_pipe.sv
// Pipelined min/max reduction tree over NUM_IN operands with valid/ready flow control.
// Optional winner-index output enabled by defining FIND_EXTREME_INDEX_EN.
module find_extreme_pipe #(
    parameter int NUM_IN = 8,
    parameter int DATA_W = 16,
    parameter int SIGNED = 0,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_IN*DATA_W-1:0] in_data,
    input  logic                     in_max,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CNT_W-1:0]         result_cnt
`ifdef FIND_EXTREME_INDEX_EN
   ,output logic [$clog2(NUM_IN)-1:0] out_index
`endif
);

    localparam int LEVELS = $clog2(NUM_IN);
    localparam int P      = 1 << LEVELS;
    localparam logic [DATA_W-1:0] ALL_ONES = '1;
    localparam logic [DATA_W-1:0] PAD_MIN  = (SIGNED != 0) ? (ALL_ONES >> 1) : ALL_ONES;
    localparam logic [DATA_W-1:0] PAD_MAX  = (SIGNED != 0) ? ~(ALL_ONES >> 1) : '0;

    // Heap-ordered tree: node 1 is the root, leaves are P..2P-1, children of n are 2n and 2n+1.
    logic [DATA_W-1:0] node_q [1:2*P-1];
    logic [DATA_W-1:0] node_d [1:2*P-1];
    logic [LEVELS:0]   valid_q;
    logic [LEVELS-1:0] max_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              advance;

    function automatic logic right_wins(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r,
                                        input logic is_max);
        logic lt, gt;
        if (SIGNED != 0) begin
            lt = $signed(r) < $signed(l);
            gt = $signed(r) > $signed(l);
        end else begin
            lt = r < l;
            gt = r > l;
        end
        return is_max ? gt : lt;
    endfunction

    assign advance    = !valid_q[LEVELS] || out_ready;
    assign in_ready   = advance;
    assign out_valid  = valid_q[LEVELS];
    assign out_data   = node_q[1];
    assign result_cnt = cnt_q;

    always_comb begin
        for (int n = 1; n < 2*P; n++) node_d[n] = node_q[n];
        for (int k = 0; k < NUM_IN; k++) node_d[P+k] = in_data[k*DATA_W +: DATA_W];
        // Padding leaves carry the identity of the beat's own mode so they can never win.
        for (int k = NUM_IN; k < P; k++) node_d[P+k] = in_max ? PAD_MAX : PAD_MIN;
        for (int l = 1; l <= LEVELS; l++) begin
            for (int n = (P >> l); n < ((2*P) >> l); n++) begin
                node_d[n] = right_wins(node_q[2*n], node_q[2*n+1], max_q[l-1]) ?
                            node_q[2*n+1] : node_q[2*n];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            max_q   <= '0;
            for (int n = 1; n < 2*P; n++) node_q[n] <= '0;
        end else if (advance) begin
            valid_q  <= {valid_q[LEVELS-1:0], in_valid};
            max_q[0] <= in_max;
            for (int l = 1; l < LEVELS; l++) max_q[l] <= max_q[l-1];
            for (int n = P; n < 2*P; n++) begin
                if (in_valid) node_q[n] <= node_d[n];
            end
            // Data only moves with a valid beat so out_data keeps the last result when idle.
            for (int l = 1; l <= LEVELS; l++) begin
                for (int n = (P >> l); n < ((2*P) >> l); n++) begin
                    if (valid_q[l-1]) node_q[n] <= node_d[n];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (valid_q[LEVELS] && out_ready) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

`ifdef FIND_EXTREME_INDEX_EN
    localparam int IDX_W = LEVELS;

    logic [IDX_W-1:0] idx_q [1:P-1];
    logic [IDX_W-1:0] idx_d [1:P-1];
    logic [IDX_W-1:0] idx_c [1:2*P-1];

    always_comb begin
        for (int n = 1; n < P; n++) idx_c[n] = idx_q[n];
        for (int n = P; n < 2*P; n++) idx_c[n] = IDX_W'(n - P);
        for (int n = 1; n < P; n++) idx_d[n] = idx_q[n];
        for (int l = 1; l <= LEVELS; l++) begin
            for (int n = (P >> l); n < ((2*P) >> l); n++) begin
                idx_d[n] = right_wins(node_q[2*n], node_q[2*n+1], max_q[l-1]) ?
                           idx_c[2*n+1] : idx_c[2*n];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 1; n < P; n++) idx_q[n] <= '0;
        end else if (advance) begin
            for (int l = 1; l <= LEVELS; l++) begin
                for (int n = (P >> l); n < ((2*P) >> l); n++) begin
                    if (valid_q[l-1]) idx_q[n] <= idx_d[n];
                end
            end
        end
    end

    assign out_index = idx_q[1];
`endif

endmodule
